ds_mod_da: RTL and testbench

- Delta-sigma DAC modulator; the transmit-side counterpart of the delta-sigma ADC path.
- Accepts signed PCM samples over a valid/ready handshake and holds each sample for `osr` modulator ticks.
- Produces a first-order 1-bit PDM stream at the divided delta-sigma rate. The stream drives an external RC filter pin.
- Sits between DSP sample sources (filters, NCO) and the board-level PDM output.

---
 rtl/ds_mod_da.sv | 152 +++++++++++++++
 tb/tb_ds_mod_da.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_mod_da.sv
// -----------------------------------------------------------------------------
// ds_mod_da -- first-order delta-sigma DAC modulator (1-bit PDM output)
//
// Takes signed PCM samples over a valid/ready handshake into a one-entry
// buffer. Each sample is moved into the modulator register x once every `osr`
// modulator ticks (the sample strobe). A modulator tick (cke) occurs once every
// `div_ratio` clk cycles while `en` is high. The PDM stream drives an external
// RC reconstruction filter.
//
// Optional build macro: DSDAC_DITHER_EN
//   When defined, a 16-bit Fibonacci LFSR adds a small dither (-2..+1 LSB)
//   into the integrator sum to break idle tones on DC inputs. When undefined
//   the output is bit-exact to the plain first-order loop.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   en            modulator enable (low freezes divider, osr counter, loop)
//   s_data        signed input sample (`width` bits)
//   s_valid       s_data is valid
//   s_ready       buffer empty, a sample can be accepted this cycle
//   pdm_out       PDM bitstream
//   cke_out       one-clk pulse in the first cycle a new pdm_out is visible
//   req           one-clk pulse, registered sample strobe
//   underrun      one-clk pulse when a strobe found the buffer empty
//   underrun_cnt  saturating underrun count
// -----------------------------------------------------------------------------
module ds_mod_da #(
   parameter int width     = 16,
   parameter int div_ratio = 50,
   parameter int osr       = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic signed [width-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic                    pdm_out,
   output logic                    cke_out,
   output logic                    req,
   output logic                    underrun,
   output logic [15:0]             underrun_cnt
);

   localparam int div_w = (div_ratio > 1) ? $clog2(div_ratio) : 1;
   localparam int osr_w = (osr > 1) ? $clog2(osr) : 1;
   localparam logic [div_w-1:0] div_last = div_w'(div_ratio - 1);
   localparam logic [osr_w-1:0] osr_last = osr_w'(osr - 1);

   // Feedback levels: full-scale positive / negative, sign-extended to width+1.
   localparam logic signed [width:0] fb_pos = {2'b00, {(width-1){1'b1}}};
   localparam logic signed [width:0] fb_neg = {2'b11, {(width-1){1'b0}}};

   logic [div_w-1:0]        div_cnt;
   logic [osr_w-1:0]        osr_cnt;
   logic                    cke;
   logic                    strobe;
   logic                    xfer;
   logic                    buf_full;
   logic signed [width-1:0] buf_data;
   logic signed [width-1:0] x;
   logic signed [width:0]   fb;
   logic signed [width:0]   e;
   logic signed [width+1:0] i1;
   logic signed [width+1:0] s_sum;

   assign cke     = en && (div_cnt == div_last);
   assign strobe  = cke && (osr_cnt == osr_last);
   assign s_ready = !buf_full;
   assign xfer    = s_valid && s_ready;

`ifdef DSDAC_DITHER_EN
   logic [15:0]             lfsr;
   logic signed [width+1:0] dith;

   // lfsr[1:0] read as a 2-bit signed value gives -2..+1.
   assign dith = {{width{lfsr[1]}}, lfsr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else if (cke) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end
`endif

   // NOTE: every signal written here is assigned on every pass, so no latch
   // can be inferred; add a default first if a branch is ever introduced.
   always_comb begin
      fb = pdm_out ? fb_pos : fb_neg;
      e  = {x[width-1], x} - fb;
`ifdef DSDAC_DITHER_EN
      s_sum = i1 + {e[width], e} + dith;
`else
      s_sum = i1 + {e[width], e};
`endif
   end

   // Tick divider, osr counter and the modulator loop, all frozen by en=0.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         osr_cnt <= '0;
         i1      <= '0;
         pdm_out <= 1'b0;
         cke_out <= 1'b0;
      end else begin
         cke_out <= cke;
         if (cke) begin
            div_cnt <= '0;
            osr_cnt <= (osr_cnt == osr_last) ? '0 : osr_cnt + 1'b1;
            i1      <= s_sum;
            pdm_out <= ~s_sum[width+1];
         end else if (en) begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // One-entry input buffer and sample strobe. The loop above reads the old x
   // on the strobe edge, so a newly loaded sample takes effect from the next
   // tick. A transfer coinciding with a strobe can only happen with the buffer
   // empty: that strobe is an underrun and the new sample stays in buf_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full     <= 1'b0;
         buf_data     <= '0;
         x            <= '0;
         req          <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         req      <= strobe;
         underrun <= strobe && !buf_full;
         if (strobe && buf_full) begin
            x        <= buf_data;
            buf_full <= 1'b0;
         end else if (xfer) begin
            buf_data <= s_data;
            buf_full <= 1'b1;
         end
         if (strobe && !buf_full && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ds_mod_da.sv
// -----------------------------------------------------------------------------
// tb_ds_mod_da -- self-checking bench for ds_mod_da (dither disabled build).
//
// Main instance: width=16, div_ratio=4, osr=64. Samples handed to the DUT are
// pushed into a scoreboard queue when accepted and popped at each req; the
// popped value feeds a reference first-order modulator that predicts every
// PDM bit. Second instance (div_ratio=1, osr=1, never fed) runs alongside to
// drive the underrun counter into saturation.
// -----------------------------------------------------------------------------
module tb_ds_mod_da;

   localparam int width     = 16;
   localparam int div_ratio = 4;
   localparam int osr       = 64;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    en  = 1'b1;
   logic signed [width-1:0] s_data = '0;
   logic                    s_valid = 1'b0;
   logic                    s_ready;
   logic                    pdm_out;
   logic                    cke_out;
   logic                    req;
   logic                    underrun;
   logic [15:0]             underrun_cnt;

   logic                    rst_b = 1'b1;
   logic                    s_ready_b;
   logic                    pdm_b;
   logic                    cke_b;
   logic                    req_b;
   logic                    und_b;
   logic [15:0]             ucnt_b;

   always #5 clk = ~clk;

   ds_mod_da #(.width(width), .div_ratio(div_ratio), .osr(osr)) dut (
      .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .pdm_out(pdm_out), .cke_out(cke_out), .req(req),
      .underrun(underrun), .underrun_cnt(underrun_cnt)
   );

   ds_mod_da #(.width(16), .div_ratio(1), .osr(1)) dut_sat (
      .clk(clk), .rst(rst_b), .en(1'b1), .s_data(16'sd0), .s_valid(1'b0),
      .s_ready(s_ready_b), .pdm_out(pdm_b), .cke_out(cke_b), .req(req_b),
      .underrun(und_b), .underrun_cnt(ucnt_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference model and scoreboard state.
   longint                  m_i1 = 0;
   longint                  m_x  = 0;
   bit                      m_pdm = 1'b0;
   longint                  sb_q[$];
   logic signed [width-1:0] src_q[$];
   bit                      feed_const = 1'b0;
   logic signed [width-1:0] feed_val = '0;
   bit                      acc_pending = 1'b0;
   logic signed [width-1:0] acc_data = '0;
   int                      exp_ucnt = 0;
   int                      ticks_since_req = 0;
   int                      ticks = 0;
   int                      ones = 0;
   int                      n_acc = 0;
   bit                      sat_done = 1'b0;

   // One clk cycle: observe at the falling edge, update model, then drive.
   task automatic cycle();
      longint fb;
      longint s;
      bit     exp_und;
      @(negedge clk);
      if (cke_out) begin
         fb    = m_pdm ? 32767 : -32768;
         s     = m_i1 + (m_x - fb);
         m_i1  = s;
         m_pdm = (s >= 0);
         ticks++;
         ticks_since_req++;
         if (pdm_out) ones++;
      end
      check("pdm", pdm_out, m_pdm);
      if (!en) check("cke_while_disabled", cke_out, 0);
      exp_und = 1'b0;
      if (req) begin
         check("ticks_per_strobe", ticks_since_req, osr);
         ticks_since_req = 0;
         if (sb_q.size() > 0) begin
            m_x = sb_q.pop_front();
         end else begin
            exp_und = 1'b1;
            if (exp_ucnt < 65535) exp_ucnt++;
         end
      end
      check("underrun", underrun, exp_und);
      check("underrun_cnt", underrun_cnt, exp_ucnt);
      if (acc_pending) begin
         sb_q.push_back(longint'(acc_data));
         acc_pending = 1'b0;
         n_acc++;
      end
      if (feed_const && src_q.size() == 0) src_q.push_back(feed_val);
      if (s_ready && src_q.size() > 0) begin
         s_data      = src_q.pop_front();
         s_valid     = 1'b1;
         acc_pending = 1'b1;
         acc_data    = s_data;
      end else begin
         s_valid = 1'b0;
      end
   endtask

   task automatic run_until_req(input int budget);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!req && n < budget);
      check("req_within_budget", req, 1);
   endtask

   // Reset asserted between clock edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst     = 1'b1;
      s_valid = 1'b0;
      en      = 1'b1;
      #1;
      check("rst_pdm_out", pdm_out, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_underrun_cnt", underrun_cnt, 0);
      check("rst_req", req, 0);
      check("rst_cke_out", cke_out, 0);
      check("rst_underrun", underrun, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_i1 = 0;
      m_x = 0;
      m_pdm = 1'b0;
      sb_q.delete();
      src_q.delete();
      feed_const = 1'b0;
      acc_pending = 1'b0;
      exp_ucnt = 0;
      ticks_since_req = 0;
   endtask

   task automatic density(input logic signed [width-1:0] val, input int lo, input int hi,
                          input string tag);
      int c;
      do_reset();
      feed_const = 1'b1;
      feed_val   = val;
      run_until_req(400);
      ones  = 0;
      ticks = 0;
      c     = 0;
      while (ticks < 1024 && c < 5000) begin
         cycle();
         c++;
      end
      check({tag, "_clks_per_1024_ticks"}, c, 1024 * div_ratio);
      check($sformatf("%s_ones=%0d_within_%0d..%0d", tag, ones, lo, hi),
            (ones >= lo && ones <= hi), 1);
   endtask

   // Saturation run on the fast instance: one strobe per clk, never fed.
   initial begin
      int pulses;
      pulses = 0;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      for (int cyc = 0; cyc < 66000; cyc++) begin
         @(negedge clk);
         if (und_b) pulses++;
         check("sat_underrun_cnt", ucnt_b, (pulses > 65535) ? 65535 : pulses);
      end
      check("sat_still_pulsing", und_b, 1);
      check("sat_req_with_underrun", req_b, 1);
      check("sat_past_limit", (pulses > 65535), 1);
      check("sat_final_cnt", ucnt_b, 65535);
      sat_done = 1'b1;
   end

   initial begin
      int k;

      // Back-pressure: 0x1000 accepted, ready low until the strobe, then
      // 0x2000 accepted in the req cycle.
      do_reset();
      src_q.push_back(16'sh1000);
      src_q.push_back(16'sh2000);
      cycle();
      check("bp_first_driven", s_valid, 1);
      k = 0;
      while (k < 400) begin
         cycle();
         k++;
         if (req) break;
         check("bp_ready_low_while_full", s_ready, 0);
      end
      check("bp_req_seen", req, 1);
      check("bp_ready_at_req", s_ready, 1);
      cycle();
      check("bp_ready_low_after_second", s_ready, 0);
      run_until_req(400);
      repeat (300) cycle();

      // Underrun: one sample, then five starved strobes.
      do_reset();
      src_q.push_back(16'sh2000);
      run_until_req(400);
      for (int i = 0; i < 5; i++) begin
         run_until_req(400);
         check("ur_pulse_with_req", underrun, 1);
      end
      check("ur_cnt_is_5", underrun_cnt, 5);
      repeat (100) cycle();

      // Mid-stream reset with pdm_out high and a nonzero underrun count.
      k = 0;
      while (!pdm_out && k < 20) begin
         cycle();
         k++;
      end
      check("pre_reset_pdm_high", pdm_out, 1);

      // Density at the limits and midpoints.
      density(16'sd0,      511, 513,  "zero");
      density(16'sd16384,  766, 770,  "half");
      density(-16'sd32768, 0,   1,    "neg_fs");
      density(16'sd32767,  1023, 1024, "pos_fs");

      // Enable freeze: loop holds for 100 clks, one handshake lands in buf.
      do_reset();
      feed_const = 1'b1;
      feed_val   = -16'sd12000;
      run_until_req(400);
      feed_const = 1'b0;
      run_until_req(400);
      repeat (37) cycle();
      en = 1'b0;
      src_q.push_back(16'sh3000);
      k = n_acc;
      repeat (100) cycle();
      check("en_off_one_accept", n_acc - k, 1);
      check("en_off_buf_full", s_ready, 0);
      en = 1'b1;
      run_until_req(400);
      repeat (600) cycle();

      k = 0;
      while (!sat_done && k < 100000) begin
         @(negedge clk);
         k++;
      end
      check("sat_run_done", sat_done, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
